// File: rtl/fetch_stage.sv
// Purpose : MIPS fetch stage; holds F_pc, addresses instruction memory, fills the F/D register.
// Latency : 1 cycle; the instruction at F_pc in cycle n is on D_instr/D_pc in cycle n+1.
// Backpressure: stall holds F_pc and the F/D register; D_clr loads a bubble when not stalled.
//
// Ports:
//   clk, reset      single clock, asynchronous active-high reset
//   npc             next fetch PC from decode's next-PC logic (loaded unless stalled)
//   stall, D_clr    hold F_pc + F/D / load a bubble into F/D (stall wins)
//   im_rdata        instruction word read combinationally at im_addr
//   im_addr         word index (F_pc - IM_BASE) >> 2, low $clog2(IM_WORDS) bits
//   F_pc            current fetch PC
//   D_pc, D_instr, D_valid, D_adel   F/D register contents seen by decode
//
// Optional feature: define FETCH_ADEL_EN to flag misaligned / out-of-range fetches
// (faulting fetch delivers a nop with D_adel=1). Undefined: D_adel tied 0, addresses alias.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        D_clr,
    input  logic [31:0] im_rdata,
    output logic [31:0] im_addr,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic        D_adel
);

    localparam int unsigned AW = $clog2(IM_WORDS);
    localparam logic [31:0] ADDR_MASK = 32'((33'd1 << AW) - 33'd1);

    logic [31:0] r_fpc;
    logic [31:0] r_dpc;
    logic [31:0] r_dinstr;
    logic        r_dvalid;

    logic [31:0] w_off;
    logic [31:0] w_word_idx;
    logic        w_adel;
    logic [31:0] w_fetch_word;

    assign w_off      = r_fpc - IM_BASE;
    assign w_word_idx = w_off >> 2;
    assign im_addr    = w_word_idx & ADDR_MASK;

`ifdef FETCH_ADEL_EN
    // End bound kept 33 bits wide so a memory ending at 4 GiB does not wrap to 0.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(4 * 64'(IM_WORDS));

    logic r_dadel;

    assign w_adel = (r_fpc[1:0] != 2'b00) || (r_fpc < IM_BASE) || ({1'b0, r_fpc} >= IM_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dadel <= 1'b0;
        end else if (!stall) begin
            r_dadel <= D_clr ? 1'b0 : w_adel;
        end
    end

    assign D_adel = r_dadel;
`else
    assign w_adel = 1'b0;
    assign D_adel = 1'b0;
`endif

    // A faulting fetch must not leak whatever memory returns for a bad address.
    assign w_fetch_word = w_adel ? 32'h0 : im_rdata;

    // No arithmetic on npc: sequential and redirect paths are both resolved in decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fpc <= RESET_PC;
        end else if (!stall) begin
            r_fpc <= npc;
        end
    end

    // F/D register: stall beats clear beats load. A bubble still records F_pc for debug.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dpc    <= 32'h0;
            r_dinstr <= 32'h0;
            r_dvalid <= 1'b0;
        end else if (!stall) begin
            r_dpc <= r_fpc;
            if (D_clr) begin
                r_dinstr <= 32'h0;
                r_dvalid <= 1'b0;
            end else begin
                r_dinstr <= w_fetch_word;
                r_dvalid <= 1'b1;
            end
        end
    end

    assign F_pc    = r_fpc;
    assign D_pc    = r_dpc;
    assign D_instr = r_dinstr;
    assign D_valid = r_dvalid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 4096;

    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        D_clr;
    logic [31:0] im_rdata;
    logic [31:0] im_addr;
    logic [31:0] F_pc;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic        D_valid;
    logic        D_adel;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .npc      (npc),
        .stall    (stall),
        .D_clr    (D_clr),
        .im_rdata (im_rdata),
        .im_addr  (im_addr),
        .F_pc     (F_pc),
        .D_pc     (D_pc),
        .D_instr  (D_instr),
        .D_valid  (D_valid),
        .D_adel   (D_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory behaves as a combinational ROM indexed by the DUT's im_addr.
    logic [31:0] mem [0:IM_WORDS-1];
    assign im_rdata = mem[im_addr[11:0]];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural view: a fetch PC and the decode slot contents.
    logic [31:0] m_fpc, m_dpc, m_dinstr;
    logic        m_dvalid, m_dadel;

    typedef struct {
        logic [31:0] fpc;
        logic [31:0] imaddr;
        logic [31:0] dpc;
        logic [31:0] dinstr;
        logic        dvalid;
        logic        dadel;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] word_index(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - IM_BASE;
        return (off / 4) % IM_WORDS;
    endfunction

    function automatic logic fetch_fault(input logic [31:0] pc);
`ifdef FETCH_ADEL_EN
        longint unsigned p;
        p = longint'(pc);
        return (pc % 4 != 0) || (p < longint'(IM_BASE)) ||
               (p >= longint'(IM_BASE) + 4 * longint'(IM_WORDS));
`else
        return (pc == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_fpc    = RESET_PC;
        m_dpc    = 0;
        m_dinstr = 0;
        m_dvalid = 0;
        m_dadel  = 0;
    endtask

    task automatic model_edge(input logic [31:0] n, input logic s, input logic c);
        logic        f;
        logic [31:0] w;
        exp_t        e;
        f = fetch_fault(m_fpc);
        w = f ? 32'h0 : mem[word_index(m_fpc)];
        if (!s) begin
            m_dpc    = m_fpc;
            m_dinstr = c ? 32'h0 : w;
            m_dvalid = !c;
            m_dadel  = c ? 1'b0 : f;
            m_fpc    = n;
        end
        e.fpc    = m_fpc;
        e.imaddr = word_index(m_fpc);
        e.dpc    = m_dpc;
        e.dinstr = m_dinstr;
        e.dvalid = m_dvalid;
        e.dadel  = m_dadel;
        sb.push_back(e);
    endtask

    // Drive one cycle at the falling edge, queue its expected result, return after the edge.
    task automatic step(input logic [31:0] n, input logic s, input logic c);
        @(negedge clk);
        npc   = n;
        stall = s;
        D_clr = c;
        model_edge(n, s, c);
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("F_pc",    F_pc,    e.fpc);
            check("im_addr", im_addr, e.imaddr);
            check("D_pc",    D_pc,    e.dpc);
            check("D_instr", D_instr, e.dinstr);
            check("D_valid", {31'h0, D_valid}, {31'h0, e.dvalid});
            check("D_adel",  {31'h0, D_adel},  {31'h0, e.dadel});
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_F_pc"},    F_pc,    RESET_PC);
        check({tag, "_im_addr"}, im_addr, 32'h0);
        check({tag, "_D_pc"},    D_pc,    32'h0);
        check({tag, "_D_instr"}, D_instr, 32'h0);
        check({tag, "_D_valid"}, {31'h0, D_valid}, 32'h0);
        check({tag, "_D_adel"},  {31'h0, D_adel},  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] n;
        logic        s, c;
        int          r;
        int          budget;

        for (int i = 0; i < IM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h2408_0001;

        reset = 1'b1;
        stall = 1'b1;
        D_clr = 1'b0;
        npc   = 32'h0;
        model_reset();
        #2;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset release and first fetch
        step(32'h3004, 1'b0, 1'b0);
        check("first_D_pc",    D_pc,    32'h3000);
        check("first_D_instr", D_instr, 32'h2408_0001);
        check("first_D_valid", {31'h0, D_valid}, 32'h1);
        check("first_F_pc",    F_pc,    32'h3004);
        step(32'h3008, 1'b0, 1'b0);

        // Stall hold for 3 edges at F_pc=3008
        repeat (3) begin
            step(32'h300c, 1'b1, 1'b0);
            check("stall_F_pc", F_pc, 32'h3008);
            check("stall_D_pc", D_pc, 32'h3004);
        end
        step(32'h300c, 1'b0, 1'b0);
        check("unstall_D_pc", D_pc, 32'h3008);

        // Bubble at F_pc=300c, then clr+stall holds
        step(32'h3010, 1'b0, 1'b1);
        check("bubble_D_instr", D_instr, 32'h0);
        check("bubble_D_valid", {31'h0, D_valid}, 32'h0);
        check("bubble_D_pc",    D_pc,    32'h300c);
        step(32'h3014, 1'b1, 1'b1);
        check("clrstall_D_pc",    D_pc, 32'h300c);
        check("clrstall_D_valid", {31'h0, D_valid}, 32'h0);

        // Redirect: delay slot at 3010 kept, then target 3100
        step(32'h3100, 1'b0, 1'b0);
        check("redir_slot_D_pc", D_pc, 32'h3010);
        check("redir_F_pc",      F_pc, 32'h3100);
        step(32'h3104, 1'b0, 1'b0);
        check("redir_tgt_D_pc",  D_pc, 32'h3100);
        check("redir_tgt_D_instr", D_instr, mem[32'h40]);

        // Misaligned and below-base fetch addresses
        step(32'h3002, 1'b0, 1'b0);
        step(32'h0000, 1'b0, 1'b0);
`ifdef FETCH_ADEL_EN
        check("adel_mis_D_adel",  {31'h0, D_adel}, 32'h1);
        check("adel_mis_D_instr", D_instr, 32'h0);
`else
        check("noadel_mis_D_adel", {31'h0, D_adel}, 32'h0);
`endif
        step(32'h3000, 1'b0, 1'b0);
`ifdef FETCH_ADEL_EN
        check("adel_low_D_adel",  {31'h0, D_adel}, 32'h1);
        check("adel_low_D_instr", D_instr, 32'h0);
`else
        check("noadel_low_D_adel", {31'h0, D_adel}, 32'h0);
`endif
        // Wrap-around is passed through untouched
        step(32'hFFFF_FFFC, 1'b0, 1'b0);
        step(32'h0000_0000, 1'b0, 1'b0);
        step(32'h3000, 1'b0, 1'b0);

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 75)       n = m_fpc + 32'd4;
            else if (r < 90)  n = IM_BASE + 4 * $urandom_range(0, IM_WORDS - 1);
            else              n = $urandom;
            s = ($urandom_range(0, 99) < 20);
            c = ($urandom_range(0, 99) < 15);
            step(n, s, c);
        end

        // Asynchronous reset mid-cycle during a stall
        step(32'h3204, 1'b1, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(32'h3004, 1'b0, 1'b0);
        check("rerun_D_pc",    D_pc,    32'h3000);
        check("rerun_D_instr", D_instr, 32'h2408_0001);
        step(32'h3008, 1'b0, 1'b0);

        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        check("scoreboard_drained", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch stage of the five-stage MIPS pipeline. It holds the architectural fetch PC (`F_pc`), addresses the instruction memory, and registers the fetched instruction and its PC into the F/D pipeline register consumed by decode. Each cycle it loads the next PC computed in decode by the next-PC logic (`npc`). It supports stall (hold) and F/D bubble insertion.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_3000: value loaded into `F_pc` on reset.
- `IM_BASE`, default 32'h0000_3000: first byte address of instruction memory.
- `IM_WORDS`, default 4096: instruction memory depth in 32-bit words.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `npc`  in  32  next fetch PC from decode's next-PC logic.
- `stall`  in  1  hazard-unit stall; holds `F_pc` and the F/D register.
- `D_clr`  in  1  load a bubble into the F/D register at the next edge.
- `im_rdata`  in  32  instruction word read combinationally at `im_addr`.
- `im_addr`  out  32  word index into instruction memory: `(F_pc - IM_BASE) >> 2`, low `$clog2(IM_WORDS)` bits significant, upper bits 0.
- `F_pc`  out  32  current fetch PC; also supplied to next-PC logic for the sequential `F_pc+4` path.
- `D_pc`  out  32  PC of the instruction in decode.
- `D_instr`  out  32  instruction in decode.
- `D_valid`  out  1  1 = decode holds a real instruction; 0 = bubble.
- `D_adel`  out  1  fetch address error on the decode instruction (see Configuration).

## Operation

- PC register: `F_pc <= stall ? F_pc : npc`. No arithmetic is performed on `npc`; wrap-around at 32'hFFFF_FFFC is inherited unchanged.
- F/D register priority at each edge is reset, then stall, then clr, then load.
  - Reset: all F/D fields 0.
  - `stall=1`: all F/D fields hold, regardless of `D_clr`.
  - `D_clr=1`, `stall=0`: `D_instr<=0` (nop), `D_valid<=0`, `D_adel<=0`, and `D_pc<=F_pc`, so the bubble carries a meaningful PC for debug.
  - Otherwise: `D_pc<=F_pc`, `D_instr<=fetch_word`, `D_valid<=1`, `D_adel<=adel_f`.
- `fetch_word` is `im_rdata`, except that it is 0 when `adel_f=1`.
- Branch delay slot: the instruction after a branch or jump is always fetched and kept. There is no automatic flush on redirect; only `D_clr` inserts bubbles.
- There is no state machine beyond the PC and F/D registers. The stage is purely pipelined, with a throughput of one instruction per cycle when not stalled.

## Timing

- Reset values: `F_pc=RESET_PC`, `D_pc=0`, `D_instr=0`, `D_valid=0`, `D_adel=0`. `im_addr` follows `F_pc` combinationally.
- Assertion of `reset` takes effect immediately (asynchronous), including mid-stall and mid-run. On the first edge after deassertion, `F_pc` loads `npc` and the F/D register captures the instruction at `RESET_PC`.
- Latency: an instruction at `F_pc` in cycle n appears on `D_instr`/`D_pc` in cycle n+1.
- A redirect presented on `npc` in cycle n is fetched in cycle n+1. The instruction fetched in cycle n is the delay slot.
- `stall` is sampled at the edge. A stall lasting k cycles holds both `F_pc` and the F/D register for exactly k edges, with no instruction lost or duplicated.
- When `stall` and `D_clr` are both high, the stall wins and the F/D register holds.

## Configuration

- `FETCH_ADEL_EN` defined:
  - `adel_f = (F_pc[1:0]!=0) || F_pc<IM_BASE || F_pc>=IM_BASE+4*IM_WORDS`.
  - A faulting fetch delivers nop with `D_adel=1`, `D_valid=1`.
- `FETCH_ADEL_EN` undefined:
  - `adel_f` is constant 0 and `D_adel` is tied to 0.
  - `im_addr` uses `F_pc` unchecked; out-of-range addresses alias by truncation.

## Test plan

- Reset check: assert `reset` -> `F_pc=32'h3000`, `D_pc=0`, `D_instr=0`, `D_valid=0`. Release, drive `npc=F_pc+4`, `im_rdata=32'h2408_0001` -> next cycle `D_pc=32'h3000`, `D_instr=32'h2408_0001`, `D_valid=1`, `F_pc=32'h3004`.
- Stall hold: with `F_pc=32'h3008`, assert `stall` for 3 cycles -> `F_pc` and the D outputs unchanged for 3 edges. Release -> `D_pc=32'h3008` on the following edge.
- Bubble insertion: assert `D_clr` with `stall=0` at `F_pc=32'h300c` -> `D_instr=0`, `D_valid=0`, `D_pc=32'h300c`. Assert `D_clr` and `stall` together -> D outputs hold.
- Redirect: set `npc=32'h3100` while `F_pc=32'h3010` -> `D_pc=32'h3010` (delay slot), then `F_pc=32'h3100`, and the next D entry has `D_pc=32'h3100`.
- Address error (`FETCH_ADEL_EN` defined): `npc=32'h3002` -> one cycle later `D_adel=1`, `D_instr=0`. With `npc=32'h0` the same response. With the macro undefined, `D_adel` stays 0.
- Reset mid-run: assert `reset` asynchronously mid-cycle during a stall -> outputs return to reset values before the next edge.
